// File: rtl/loader_pkg.sv
// Shared command encodings, bank selects and state type for the program loader.
package loader_pkg;

    // First byte of every frame selects the operation.
    localparam logic [7:0] CMD_LD_INSTR = 8'hA0;
    localparam logic [7:0] CMD_LD_DATA  = 8'hA1;
    localparam logic [7:0] CMD_RUN      = 8'hA5;

    // Write target on mem_sel.
    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        HI,
        LO,
        RUN
    } state_t;

    // True for either of the two bank-load commands.
    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == CMD_LD_INSTR) || (b == CMD_LD_DATA);
    endfunction

    // Bank selected by a load command byte.
    function automatic logic bank_of(input logic [7:0] b);
        return (b == CMD_LD_DATA) ? SEL_DATA : SEL_INSTR;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream loader: fills instruction/data banks with big-endian words,
// then releases the core via cpu_run until it halts.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              hlt,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    state_t state_q, state_d;

    logic              accept;
    logic              lo_accept;
    logic [ADDR_W-1:0] addr_q;     // next address to write
    logic [7:0]        cnt_q;      // words remaining in the current frame
    logic [7:0]        hi_q;       // high byte of the word being assembled
    logic              sel_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              err_q;
    logic [15:0]       words_q;

    assign accept    = in_valid && in_ready;
    assign lo_accept = accept && (state_q == LO);

    // State register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame parsing and run/halt handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load_cmd(in_byte)) begin
                        state_d = ADDR;
                    end else if (in_byte == CMD_RUN) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    state_d = CNT;
                end
            end
            CNT: begin
                if (accept) begin
                    state_d = (in_byte == 8'd0) ? IDLE : HI;
                end
            end
            HI: begin
                if (accept) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    state_d = (cnt_q == 8'd1) ? IDLE : HI;
                end
            end
            RUN: begin
                if (hlt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; combinational so reset drops cpu_run at once.
    always_comb begin
        in_ready = 1'b1;
        cpu_run  = 1'b0;
        if (state_q == RUN) begin
            in_ready = 1'b0;
            cpu_run  = 1'b1;
        end
    end

    // Datapath: word assembly, write strobe, address/count tracking, flags.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            sel_q      <= SEL_INSTR;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            we_q <= lo_accept;

            if (accept && (state_q == IDLE)) begin
                done_q <= 1'b0;
                if (is_load_cmd(in_byte)) begin
                    sel_q <= bank_of(in_byte);
                end else if (in_byte != CMD_RUN) begin
                    err_q <= 1'b1;
                end
            end

            if (accept && (state_q == ADDR)) begin
                addr_q <= in_byte[ADDR_W-1:0];
            end

            if (accept && (state_q == CNT)) begin
                cnt_q <= in_byte;
            end

            if (accept && (state_q == HI)) begin
                hi_q <= in_byte;
            end

            // Address wraps naturally at ADDR_W bits.
            if (lo_accept) begin
                mem_addr_q <= addr_q;
                wdata_q    <= {hi_q, in_byte};
                addr_q     <= addr_q + 1'b1;
                cnt_q      <= cnt_q - 8'd1;
                words_q    <= words_q + 16'd1;
            end

            if ((state_q == RUN) && hlt) begin
                done_q <= 1'b1;
            end
        end
    end

    assign mem_we       = we_q;
    assign mem_sel      = sel_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = wdata_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames push expected writes,
// a negedge monitor pops and compares each write strobe.
module tb_prog_loader;

    logic        clk1;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        hlt;
    logic        cpu_run;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    typedef struct packed {
        logic        sel;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] words;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  stalls = 0;

    prog_loader #(
        .ADDR_W(7),
        .DATA_W(16)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .hlt         (hlt),
        .cpu_run     (cpu_run),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk1) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got sel=%0h addr=%0h data=%0h expected none",
                         mem_sel, mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", {24'd0, mem_sel, mem_addr, mem_wdata, words_loaded}, {24'd0, e});
            end
        end
    end

    task automatic expect_wr(input logic sel, input logic [6:0] addr, input logic [15:0] data,
                             input logic [15:0] words);
        wr_t e;
        e.sel   = sel;
        e.addr  = addr;
        e.data  = data;
        e.words = words;
        exp_q.push_back(e);
    endtask

    // Present one byte, wait (bounded) for acceptance, then drop in_valid.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk1);
        in_valid = 1'b1;
        in_byte  = b;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk1);
            guard++;
        end
        stalls += guard;
        if (guard >= 200) begin
            chk("accept_timeout", 64'd1, 64'd0);
        end
        @(posedge clk1);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        chk(name, {in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_run, done, err,
                   words_loaded},
            {1'b1, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    endtask

    initial begin
        int bad;
        int runs;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        hlt      = 1'b0;
        repeat (3) @(negedge clk1);
        check_reset_values("reset_state");
        rst = 1'b0;

        // Reset between HI and LO: no strobe, everything back to reset.
        send_byte(8'hA0);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h12);
        @(negedge clk1);
        rst = 1'b1;
        #1 check_reset_values("reset_midframe");
        @(negedge clk1);
        rst = 1'b0;

        // Instruction load, back-to-back bytes.
        expect_wr(1'b0, 7'h05, 16'h1234, 16'd1);
        expect_wr(1'b0, 7'h06, 16'hABCD, 16'd2);
        stalls = 0;
        send_byte(8'hA0);
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        chk("instr_no_stall", stalls, 0);
        repeat (2) @(negedge clk1);
        chk("instr_words", words_loaded, 16'd2);

        // Data load wrapping 0x7F -> 0x00.
        expect_wr(1'b1, 7'h7F, 16'h0011, 16'd3);
        expect_wr(1'b1, 7'h00, 16'h0022, 16'd4);
        send_byte(8'hA1);
        send_byte(8'h7F);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h00);
        send_byte(8'h22);
        repeat (2) @(negedge clk1);
        chk("data_sel", mem_sel, 1'b1);

        // Zero count then bad command.
        send_byte(8'hA0);
        send_byte(8'h10);
        send_byte(8'h00);
        @(negedge clk1);
        chk("zero_cnt_err_clear", err, 1'b0);
        send_byte(8'h3C);
        @(negedge clk1);
        chk("bad_cmd_err", err, 1'b1);
        chk("bad_cmd_idle", {in_ready, cpu_run}, {1'b1, 1'b0});
        chk("bad_cmd_words", words_loaded, 16'd4);
        expect_wr(1'b1, 7'h00, 16'hFFFF, 16'd5);
        send_byte(8'hA1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'hFF);
        repeat (2) @(negedge clk1);
        chk("err_sticky", err, 1'b1);

        // Run for 20 cycles, then halt.
        send_byte(8'hA5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (!cpu_run || in_ready) bad++;
        end
        chk("run_cycles_bad", bad, 0);
        hlt = 1'b1;
        @(posedge clk1);
        #1 hlt = 1'b0;
        @(negedge clk1);
        chk("halt_outputs", {cpu_run, done, in_ready}, {1'b0, 1'b1, 1'b1});
        send_byte(8'hA0);
        @(negedge clk1);
        chk("done_cleared", done, 1'b0);
        send_byte(8'h00);
        send_byte(8'h00);

        // hlt already high on entry: one cycle of cpu_run.
        @(negedge clk1);
        hlt = 1'b1;
        send_byte(8'hA5);
        runs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk1);
            if (cpu_run) runs++;
        end
        hlt = 1'b0;
        chk("hlt_preset_run_len", runs, 1);
        chk("hlt_preset_done", done, 1'b1);

        // Byte held during RUN is consumed only after halt.
        send_byte(8'hA5);
        @(negedge clk1);
        in_valid = 1'b1;
        in_byte  = 8'hA0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk1);
            if (in_ready || !cpu_run) bad++;
        end
        chk("bp_held_bad", bad, 0);
        hlt = 1'b1;
        @(posedge clk1);
        #1 hlt = 1'b0;
        @(negedge clk1);
        chk("bp_after_halt", {in_ready, done, cpu_run}, {1'b1, 1'b1, 1'b0});
        @(posedge clk1);
        #1 in_valid = 1'b0;
        @(negedge clk1);
        chk("bp_consumed_done", done, 1'b0);
        expect_wr(1'b0, 7'h03, 16'hBEEF, 16'd6);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
        repeat (3) @(negedge clk1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer that fills the processor's instruction and data banks, then starts the core and waits for halt.
- Accepts a byte stream with a valid/ready handshake and assembles big-endian 16-bit words.
- Issues single-cycle write strobes to the selected bank.
- Holds the core stopped via cpu_run until a RUN command arrives, then releases it until hlt.

Parameters:
- ADDR_W, 7, memory word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, memory word width; fixed at two bytes per word.

Ports:
- clk1  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte stream valid.
- in_byte  input  8  byte stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  one-cycle write strobe.
- mem_sel  output  1  write target: 0 = instruction bank, 1 = data bank.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  DATA_W  write data.
- hlt  input  1  processor halt flag.
- cpu_run  output  1  processor enable.
- done  output  1  a run has completed with hlt seen.
- err  output  1  sticky: an unknown command byte was received.
- words_loaded  output  16  running count of words written since reset; wraps.

Behaviour:
- Byte transfer: a byte is accepted only on a rising edge where in_valid and in_ready are both high.
- in_ready is high in every state except RUN.
- Commands (first byte of a frame):
  - 0xA0 = load instruction bank.
  - 0xA1 = load data bank.
  - 0xA5 = run.
  - Any other value sets err, the byte is consumed, and the state stays IDLE.
- Load frame: cmd, start address byte (low ADDR_W bits used), count byte N (0..255), then 2N data bytes, high byte first.
- State machine:
  - IDLE: 0xA0/0xA1 -> ADDR, latching mem_sel. 0xA5 -> RUN. Any other byte -> err, stay in IDLE.
  - ADDR: accept byte -> CNT.
  - CNT: N=0 -> IDLE with no writes. Otherwise -> HI.
  - HI: accept byte -> LO.
  - LO: accept byte -> write. Then go to HI if words remain, else IDLE.
  - RUN: cpu_run=1. When hlt is sampled high, next cycle cpu_run=0, done=1, state -> IDLE.
- Write timing:
  - mem_we is registered and pulses high the cycle after the LO byte is accepted.
  - mem_addr and mem_wdata are valid in that same cycle.
  - The address register increments after each write. 0x7F+1 wraps to 0x00.
  - words_loaded increments with each write strobe.
- Back-to-back words at full rate: one write every two accepted bytes, with no stall.
- done clears when the next command byte is accepted. err clears only on reset.
- If hlt is already high on entry to RUN, cpu_run is high for exactly one cycle.
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_run=0, done=0, err=0, words_loaded=0.
- Reset mid-frame: the frame is abandoned, any pending write strobe is dropped, and cpu_run drops immediately.
- in_valid held high in RUN: the byte is not consumed and is accepted once the state returns to IDLE.

Decomposition:
- Shared package (loader_pkg) holds:
  - command constants CMD_LD_INSTR=8'hA0, CMD_LD_DATA=8'hA1, CMD_RUN=8'hA5;
  - the state enum IDLE/ADDR/CNT/HI/LO/RUN;
  - bank-select constants SEL_INSTR=0, SEL_DATA=1.
- No sub-module is required. The byte-to-word assembly is small enough to stay inline.

Test Plan:
- Reset mid-frame: reset asserted between HI and LO of a frame -> mem_we never pulses, all outputs return to reset values. The next full frame loads correctly.
- Instruction load: send A0 05 02 12 34 AB CD -> two strobes with mem_sel=0: (addr 5, 0x1234) and (addr 6, 0xABCD). words_loaded=2, in_ready stays high throughout.
- Data load with wrap: send A1 7F 02 00 11 00 22 -> writes (0x7F, 0x0011) then (0x00, 0x0022), mem_sel=1.
- Zero count and bad command: send A0 10 00, then 3C -> no write strobes, err=1, state IDLE. A following A1 00 01 FF FF still writes (0x00, 0xFFFF).
- Run/halt: send A5, raise hlt 20 cycles later -> cpu_run high for those cycles, in_ready=0 throughout. Then cpu_run=0 and done=1. Sending A0 clears done.
- Backpressure: in_valid high with byte 0xA0 during RUN -> not consumed, in_ready=0. The byte is accepted on the first IDLE cycle after hlt.
